// File: rtl/jesd204_fec_lfsr_multilane.sv
// Multi-lane JESD204C 64B/66B FEC remainder engine: each lane divides its bit stream by g(x)
// and the block framing either emits the 26-bit parity or checks a received block plus parity.
module jesd204_fec_lfsr_multilane #(
    parameter int unsigned              NUM_LANES       = 4,
    parameter int unsigned              LFSR_WIDTH      = 26,
    parameter logic [LFSR_WIDTH-1:0]    LFSR_POLYNOMIAL = 26'h2210110,
    parameter logic [LFSR_WIDTH-1:0]    RESET_VAL       = '0,
    parameter int unsigned              MAX_SHIFT_CNT   = 64,
    parameter int unsigned              BLOCK_BITS      = 2048
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 restart,
    input  logic                                 mode,
    input  logic                                 in_valid,
    input  logic [$clog2(MAX_SHIFT_CNT)-1:0]     shift_cnt,
    input  logic [NUM_LANES*MAX_SHIFT_CNT-1:0]   data_in,
    output logic [NUM_LANES*MAX_SHIFT_CNT-1:0]   data_out,
    output logic                                 out_valid,
    output logic [NUM_LANES*LFSR_WIDTH-1:0]      parity_out,
    output logic                                 parity_valid,
    output logic                                 check_valid,
    output logic [NUM_LANES-1:0]                 check_ok,
    output logic                                 frame_err
);

    localparam int unsigned CNT_W = $clog2(BLOCK_BITS + MAX_SHIFT_CNT + 1);
    localparam int unsigned SW    = NUM_LANES * LFSR_WIDTH;

    typedef enum logic {
        StData,
        StParity
    } phase_e;

    phase_e              r_phase;
    phase_e              w_phase_nxt;
    phase_e              w_base_phase;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_base_cnt;
    logic [CNT_W-1:0]    w_k;
    logic [CNT_W-1:0]    w_remain;
    logic [CNT_W-1:0]    w_take;
    logic [SW-1:0]       r_lfsr;
    logic [SW-1:0]       w_lfsr_nxt;
    logic [SW-1:0]       w_base_lfsr;
    logic [SW-1:0]       w_absorbed;
    logic                r_mode;
    logic                w_mode_nxt;
    logic                w_mode_eff;
    logic                w_block_start;
    logic                w_straddle;
    logic                w_done;
    logic [SW-1:0]       w_parity_nxt;
    logic                w_pv_nxt;
    logic                w_cv_nxt;
    logic [NUM_LANES-1:0] w_ok_nxt;
    logic                w_ferr_nxt;
    logic [LFSR_WIDTH-1:0] w_s;
    logic                w_fb;

    // restart takes effect before the coincident beat, so that beat opens the new block
    always_comb begin
        w_base_phase  = restart ? StData : r_phase;
        w_base_cnt    = restart ? '0 : r_cnt;
        w_base_lfsr   = restart ? {NUM_LANES{RESET_VAL}} : r_lfsr;
        w_block_start = (w_base_phase == StData) && (w_base_cnt == '0);
        w_mode_eff    = w_block_start ? mode : r_mode;
        w_k           = CNT_W'(shift_cnt) + CNT_W'(1);
        w_remain      = (w_base_phase == StData) ? CNT_W'(BLOCK_BITS) - w_base_cnt
                                                 : CNT_W'(LFSR_WIDTH) - w_base_cnt;
        w_straddle    = w_k > w_remain;
        w_take        = w_straddle ? w_remain : w_k;
        w_done        = (w_take == w_remain);
    end

    always_comb begin
        w_absorbed = w_base_lfsr;
        w_s        = '0;
        w_fb       = 1'b0;
        for (int n = 0; n < NUM_LANES; n++) begin
            w_s = w_base_lfsr[n*LFSR_WIDTH +: LFSR_WIDTH];
            for (int i = 0; i < MAX_SHIFT_CNT; i++) begin
                if (CNT_W'(i) < w_take) begin
                    w_fb = w_s[0] ^ data_in[n*MAX_SHIFT_CNT + i];
                    w_s  = {1'b0, w_s[LFSR_WIDTH-1:1]} ^ ({LFSR_WIDTH{w_fb}} & LFSR_POLYNOMIAL);
                end
            end
            w_absorbed[n*LFSR_WIDTH +: LFSR_WIDTH] = w_s;
        end
    end

    always_comb begin
        w_phase_nxt  = w_base_phase;
        w_cnt_nxt    = w_base_cnt;
        w_lfsr_nxt   = w_base_lfsr;
        w_mode_nxt   = r_mode;
        w_parity_nxt = parity_out;
        w_ok_nxt     = check_ok;
        w_pv_nxt     = 1'b0;
        w_cv_nxt     = 1'b0;
        w_ferr_nxt   = frame_err;
        if (in_valid) begin
            w_mode_nxt = w_mode_eff;
            w_cnt_nxt  = w_base_cnt + w_take;
            w_lfsr_nxt = w_absorbed;
            if (w_straddle) begin
                w_ferr_nxt = 1'b1;
            end
            if (w_done) begin
                w_cnt_nxt = '0;
                unique case (w_base_phase)
                    StData: begin
                        if (w_mode_eff) begin
                            // remainder carries into the parity phase untouched
                            w_phase_nxt = StParity;
                        end else begin
                            w_parity_nxt = w_absorbed;
                            w_pv_nxt     = 1'b1;
                            w_lfsr_nxt   = {NUM_LANES{RESET_VAL}};
                        end
                    end
                    StParity: begin
                        for (int n = 0; n < NUM_LANES; n++) begin
                            w_ok_nxt[n] = (w_absorbed[n*LFSR_WIDTH +: LFSR_WIDTH] == '0);
                        end
                        w_parity_nxt = w_absorbed;
                        w_cv_nxt     = 1'b1;
                        w_lfsr_nxt   = {NUM_LANES{RESET_VAL}};
                        w_phase_nxt  = StData;
                    end
                    default: w_phase_nxt = StData;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_phase      <= StData;
            r_cnt        <= '0;
            r_lfsr       <= {NUM_LANES{RESET_VAL}};
            r_mode       <= 1'b0;
            data_out     <= '0;
            out_valid    <= 1'b0;
            parity_out   <= '0;
            parity_valid <= 1'b0;
            check_valid  <= 1'b0;
            check_ok     <= '0;
            frame_err    <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_cnt        <= w_cnt_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_mode       <= w_mode_nxt;
            data_out     <= data_in;
            out_valid    <= in_valid;
            parity_out   <= w_parity_nxt;
            parity_valid <= w_pv_nxt;
            check_valid  <= w_cv_nxt;
            check_ok     <= w_ok_nxt;
            frame_err    <= w_ferr_nxt;
        end
    end

endmodule
